audio_peak_meter: RTL and testbench
===================================

// Module: audio_peak_meter
// PURPOSE
//  Producer side of the hex-display meter path: measures absolute peak level of the audio sample
//  stream over a fixed window of samples, converts it to packed BCD with a sequential
//  double-dabble converter, and holds a 32-bit word for the 8-digit seven-segment display driver.
//  Sits between the audio sample bus and the display wrapper; display digit k = meter_out[4k+3:4k].
// PARAMETERS
//  SAMPLE_W  24     signed sample width (two's complement)
//  WINDOW    48000  valid samples per measurement window; must be >= SAMPLE_W+2
// PORTS
//  clk           in   1   system clock; single clock domain
//  reset         in   1   synchronous, active-high reset
//  sample_in     in   24  signed audio sample (SAMPLE_W)
//  sample_valid  in   1   sample_in is valid this cycle; at most one sample per cycle, no backpressure
//  clear         in   1   synchronous: restart current window (peak and sample count to 0)
//  meter_out     out  32  packed BCD peak, 8 digits, digit 0 in [3:0]; reset 32'h0
//  meter_valid   out  1   one-cycle pulse when meter_out updates; reset 0
//  busy          out  1   converter active; reset 0
// BEHAVIOUR
//  - abs: |sample|, with -2^(SAMPLE_W-1) saturating to 2^(SAMPLE_W-1)-1. Result is SAMPLE_W-1 bits unsigned.
//  - Peak: on sample_valid, peak <= max(peak, abs). Sample counter increments mod WINDOW.
//  - Window end: sample_valid while count==WINDOW-1 (edge E0). Conversion input <= max(peak, abs of this sample).
//    Peak <= 0 and count <= 0, so the next window starts clean.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE:
//    IDLE: at E0, load converter (bcd=0, bin=latched peak) -> SHIFT with iter=0.
//    SHIFT: each edge, add 3 to every BCD digit >=5, then shift {bcd,bin} left 1.
//      After SAMPLE_W shifts (E1..E24 at default) -> DONE.
//    DONE: next edge (E25) meter_out <= bcd[31:0], meter_valid <= 1 -> IDLE. meter_valid clears at E26.
//  - Latency: SAMPLE_W+1 cycles from window-end edge to meter_out/meter_valid. busy=1 in SHIFT and DONE.
//  - Max value 8388607 -> 32'h0838_8607; digit 7 is always 0 at default width.
//  - meter_out holds between updates; never changes except at the DONE edge or reset.
//  - clear with sample_valid in the same cycle: clear wins and that sample is discarded.
//    clear does not abort a conversion already in progress.
//  - Window end while busy (only possible if the WINDOW constraint is violated): the new peak is dropped.
//    Counter and peak still restart, and the conversion in progress completes unchanged.
//  - reset at any time, including mid-SHIFT: all state and outputs return to reset values.
//    No meter_valid pulse is produced.
//  - All arithmetic is unsigned on the abs value. Each BCD digit adjust is 4-bit with no carry between digits before the shift.
// STRUCTURE
//  - meter_pkg: SAMPLE_W default, NUM_DIGITS=8, BCD_W=32, enum typedef for states {IDLE,SHIFT,DONE}.
//  - Sub-module bcd_converter: sequential double-dabble with start/busy/done and a bcd_out port.
//    Owns the FSM and iteration counter.
//  - Top level: abs/saturate, peak register, window counter, output register.
// TESTING  (bench overrides WINDOW=32)
//  1. reset held 3 cycles -> meter_out=32'h0, meter_valid=0, busy=0. Outputs stay so with no samples.
//  2. Window of samples {+100,-1234,+500, rest 0} -> exactly one meter_valid pulse 25 cycles after
//     the 32nd sample, meter_out=32'h0000_1234.
//  3. Single sample -8388608 in a window -> meter_out=32'h0838_8607 (saturation).
//  4. Sample 9999 with clear in the same cycle, then 32 zero samples -> meter_out=32'h0.
//     The window boundary counts from after clear.
//  5. reset pulsed at E10 of a conversion -> meter_out=0, no pulse. Next window with peak 77 -> 32'h77.
//  6. Back-to-back windows with peaks 500 then 42 -> meter_out 32'h500, then 32'h42.
//     The second window ignores the first window's peak. busy is low between conversions.

Source files
------------

// File: rtl/meter_pkg.sv
// Purpose: shared constants, converter state type and BCD digit-adjust helper
//          for the audio peak meter.
// Contents:
//   SAMPLE_W_DEF  default signed sample width
//   NUM_DIGITS    BCD digits held in the display word
//   DIGIT_W       bits per BCD digit
//   BCD_W         width of the packed BCD word
//   conv_state_e  double-dabble converter states
//   dd_adjust     add 3 to every digit >= 5 (no carry between digits)
package meter_pkg;

    localparam int unsigned SAMPLE_W_DEF = 24;
    localparam int unsigned NUM_DIGITS   = 8;
    localparam int unsigned DIGIT_W      = 4;
    localparam int unsigned BCD_W        = NUM_DIGITS * DIGIT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    // Each digit is adjusted independently in 4 bits; a digit <= 9 never overflows.
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0]   res;
        logic [DIGIT_W-1:0] dig;
        res = bcd;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            dig = bcd[i*DIGIT_W +: DIGIT_W];
            if (dig >= DIGIT_W'(5)) begin
                res[i*DIGIT_W +: DIGIT_W] = dig + DIGIT_W'(3);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_converter.sv
// Purpose: sequential double-dabble binary-to-BCD converter.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   start       load din and begin a conversion (ignored unless idle)
//   din         unsigned binary value, SAMPLE_W bits
//   busy        registered; high while shifting or in the final state
//   done_c      combinational; high for the one cycle the result is complete
//   bcd_out     working BCD register; final value valid while done_c is high
module bcd_converter
    import meter_pkg::*;
#(
    parameter int unsigned SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [SAMPLE_W-1:0] din,
    output logic                busy,
    output logic                done_c,
    output logic [BCD_W-1:0]    bcd_out
);

    localparam int unsigned ITER_W = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;
    localparam int unsigned SR_W   = BCD_W + SAMPLE_W;

    conv_state_e         state, state_d;
    logic [BCD_W-1:0]    bcd, bcd_d;
    logic [SAMPLE_W-1:0] bin, bin_d;
    logic [ITER_W-1:0]   iter, iter_d;
    logic                busy_d;
    logic [BCD_W-1:0]    adj_c;
    logic [SR_W-1:0]     shifted_c;

    // One double-dabble step: adjust digits, then shift {bcd,bin} left by one.
    assign adj_c     = dd_adjust(bcd);
    assign shifted_c = {adj_c, bin} << 1;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            bcd   <= '0;
            bin   <= '0;
            iter  <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            bcd   <= bcd_d;
            bin   <= bin_d;
            iter  <= iter_d;
            busy  <= busy_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state;
        bcd_d   = bcd;
        bin_d   = bin;
        iter_d  = iter;
        case (state)
            IDLE: begin
                if (start) begin
                    bcd_d   = '0;
                    bin_d   = din;
                    iter_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d  = shifted_c[SR_W-1:SAMPLE_W];
                bin_d  = shifted_c[SAMPLE_W-1:0];
                iter_d = iter + ITER_W'(1);
                if (iter == ITER_W'(SAMPLE_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    assign done_c  = (state == DONE);
    assign bcd_out = bcd;

endmodule

// File: rtl/audio_peak_meter.sv
// Purpose: windowed absolute-peak meter for a signed audio stream; the peak of
//          each window is converted to packed BCD for an 8-digit display.
// Ports:
//   clk           system clock
//   reset         synchronous active-high reset
//   sample_in     signed audio sample, SAMPLE_W bits
//   sample_valid  sample_in valid this cycle
//   clear         restart the current window (peak and count to zero)
//   meter_out     packed BCD peak, digit k in [4k+3:4k]; holds between updates
//   meter_valid   one-cycle pulse when meter_out updates
//   busy          converter active
module audio_peak_meter
    import meter_pkg::*;
#(
    parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
    parameter int unsigned WINDOW   = 48000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic                clear,
    output logic [BCD_W-1:0]    meter_out,
    output logic                meter_valid,
    output logic                busy
);

    localparam int unsigned ABS_W = SAMPLE_W - 1;
    localparam int unsigned CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    logic [SAMPLE_W-1:0] mag_c;
    logic [ABS_W-1:0]    abs_c;
    logic [ABS_W-1:0]    peak;
    logic [ABS_W-1:0]    peak_max_c;
    logic [CNT_W-1:0]    count;
    logic                last_c;
    logic                win_end_c;
    logic                conv_done_c;
    logic [BCD_W-1:0]    conv_bcd;

    // Magnitude; only the most negative input keeps its MSB set, which selects saturation.
    assign mag_c      = sample_in[SAMPLE_W-1] ? (~sample_in + SAMPLE_W'(1)) : sample_in;
    assign abs_c      = mag_c[SAMPLE_W-1] ? '1 : mag_c[ABS_W-1:0];
    assign peak_max_c = (abs_c > peak) ? abs_c : peak;

    assign last_c    = (count == CNT_W'(WINDOW - 1));
    assign win_end_c = sample_valid && !clear && last_c;

    // Peak tracker and window counter; clear beats a same-cycle sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak  <= '0;
            count <= '0;
        end else if (clear) begin
            peak  <= '0;
            count <= '0;
        end else if (sample_valid) begin
            if (last_c) begin
                peak  <= '0;
                count <= '0;
            end else begin
                peak  <= peak_max_c;
                count <= count + CNT_W'(1);
            end
        end
    end

    // A window end while the converter is busy is ignored by the converter.
    bcd_converter #(
        .SAMPLE_W (SAMPLE_W)
    ) u_conv (
        .clk     (clk),
        .reset   (reset),
        .start   (win_end_c),
        .din     ({1'b0, peak_max_c}),
        .busy    (busy),
        .done_c  (conv_done_c),
        .bcd_out (conv_bcd)
    );

    // Display word register.
    always_ff @(posedge clk) begin
        if (reset) begin
            meter_out   <= '0;
            meter_valid <= 1'b0;
        end else begin
            meter_valid <= conv_done_c;
            if (conv_done_c) begin
                meter_out <= conv_bcd;
            end
        end
    end

endmodule

// File: tb/tb_audio_peak_meter.sv
// Purpose: randomized scoreboard bench for audio_peak_meter with a short window.
module tb_audio_peak_meter;

    localparam int unsigned SW  = 24;
    localparam int unsigned WIN = 32;
    localparam int          LAT = 25;

    logic          clk;
    logic          reset;
    logic [SW-1:0] sample_in;
    logic          sample_valid;
    logic          clear;
    logic [31:0]   meter_out;
    logic          meter_valid;
    logic          busy;

    audio_peak_meter #(
        .SAMPLE_W (SW),
        .WINDOW   (WIN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .clear        (clear),
        .meter_out    (meter_out),
        .meter_valid  (meter_valid),
        .busy         (busy)
    );

    typedef struct {
        logic [31:0] val;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          cyc;
    int          checks;
    int          errors;
    bit          mon_en;
    int          m_peak;
    int          m_count;
    int          conv_e0;
    bit          conv_act;
    logic [31:0] exp_meter;
    logic [SW-1:0] win[WIN];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: |x| with saturation of the most negative value.
    function automatic int model_abs(input logic [SW-1:0] s);
        int v;
        v = int'($signed(s));
        if (v == -(1 << (SW - 1))) return (1 << (SW - 1)) - 1;
        return (v < 0) ? -v : v;
    endfunction

    // Reference model: decimal digits by repeated division.
    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model update for one clock edge with the given inputs.
    task automatic model_edge(input bit v, input logic [SW-1:0] s, input bit c, input bit r);
        int a;
        int m;
        if (r) begin
            m_peak    = 0;
            m_count   = 0;
            conv_act  = 0;
            exp_meter = '0;
            sb.delete();
        end else if (c) begin
            m_peak  = 0;
            m_count = 0;
        end else if (v) begin
            a = model_abs(s);
            m = (a > m_peak) ? a : m_peak;
            if (m_count == WIN - 1) begin
                if (!conv_act || cyc > conv_e0 + LAT) begin
                    sb.push_back('{to_bcd(m), cyc + LAT});
                    conv_act = 1;
                    conv_e0  = cyc;
                end
                m_peak  = 0;
                m_count = 0;
            end else begin
                m_peak  = m;
                m_count = m_count + 1;
            end
        end
    endtask

    task automatic step(input bit v, input logic [SW-1:0] s, input bit c, input bit r);
        sample_valid = v;
        sample_in    = s;
        clear        = c;
        reset        = r;
        @(posedge clk);
        #1;
        model_edge(v, s, c, r);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, SW'($urandom), 1'b0, 1'b0);
    endtask

    task automatic drive_window(input int gap_pct);
        for (int i = 0; i < int'(WIN); i++) begin
            while (int'($urandom_range(99)) < gap_pct) step(1'b0, SW'($urandom), 1'b0, 1'b0);
            step(1'b1, win[i], 1'b0, 1'b0);
        end
    endtask

    task automatic fill_window(input int amp);
        int v;
        for (int i = 0; i < int'(WIN); i++) begin
            v = (amp == 0) ? 0 : int'($urandom_range(amp)) - amp / 2;
            win[i] = SW'(v);
        end
    endtask

    function automatic logic [SW-1:0] rand_sample();
        logic [SW-1:0] s;
        s = SW'($urandom) >> $urandom_range(SW - 1);
        if ($urandom_range(1) == 1) s = -s;
        if ($urandom_range(49) == 0) s = 24'h800000;
        return s;
    endfunction

    // Monitor: pops the scoreboard on every meter_valid pulse.
    always @(negedge clk) begin
        if (mon_en) begin
            if (meter_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got meter_out %h with no pending result (cycle %0d)", meter_out, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check32("pulse_cycle", 32'(cyc), 32'(e.due));
                    check32("pulse_value", meter_out, e.val);
                    exp_meter = e.val;
                end
            end
            if (sb.size() > 0 && sb[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_pulse: got no pulse expected value %h at cycle %0d", sb[0].val, sb[0].due);
                void'(sb.pop_front());
            end
            check32("meter_hold", meter_out, exp_meter);
            check32("busy", 32'(busy),
                    32'(conv_act && cyc >= conv_e0 && cyc <= conv_e0 + LAT - 1));
        end
    end

    initial begin
        int pos;
        cyc          = 0;
        checks       = 0;
        errors       = 0;
        mon_en       = 0;
        exp_meter    = '0;
        m_peak       = 0;
        m_count      = 0;
        conv_e0      = 0;
        conv_act     = 0;
        sample_valid = 1'b0;
        sample_in    = '0;
        clear        = 1'b0;
        reset        = 1'b1;

        // Reset state and quiet outputs.
        repeat (3) step(1'b0, '0, 1'b0, 1'b1);
        check32("reset_meter_out", meter_out, 32'h0);
        check32("reset_meter_valid", 32'(meter_valid), 32'h0);
        check32("reset_busy", 32'(busy), 32'h0);
        mon_en = 1;
        idle(10);

        // Mixed-sign window.
        fill_window(0);
        win[0] = 24'd100;
        win[1] = SW'(-1234);
        win[2] = 24'd500;
        drive_window(0);
        idle(30);
        check32("peak_1234", meter_out, 32'h0000_1234);

        // Most negative sample saturates.
        fill_window(0);
        pos = int'($urandom_range(WIN - 1));
        win[pos] = 24'h800000;
        drive_window(20);
        idle(30);
        check32("saturation", meter_out, 32'h0838_8607);

        // clear discards the same-cycle sample and restarts the count.
        step(1'b1, 24'd9999, 1'b1, 1'b0);
        fill_window(0);
        drive_window(0);
        idle(30);
        check32("clear_discard", meter_out, 32'h0);

        // Reset in the middle of a conversion.
        fill_window(11110);
        win[3] = 24'd5555;
        drive_window(0);
        idle(9);
        step(1'b0, '0, 1'b0, 1'b1);
        check32("midconv_reset_out", meter_out, 32'h0);
        check32("midconv_reset_busy", 32'(busy), 32'h0);
        idle(30);
        fill_window(152);
        pos = int'($urandom_range(WIN - 1));
        win[pos] = SW'(-77);
        drive_window(10);
        idle(30);
        check32("after_reset_77", meter_out, 32'h0000_0077);

        // Back-to-back windows.
        fill_window(998);
        win[int'($urandom_range(WIN - 1))] = 24'd500;
        drive_window(0);
        fill_window(84);
        win[int'($urandom_range(WIN - 1))] = 24'd42;
        drive_window(0);
        idle(30);
        check32("back_to_back_42", meter_out, 32'h0000_0042);

        // Random traffic with gaps and occasional clears.
        for (int n = 0; n < 600; n++) begin
            step(int'($urandom_range(99)) < 75, rand_sample(), $urandom_range(99) < 2, 1'b0);
        end
        idle(30);

        check32("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
